// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e : FSM state encoding for the serial framing engines
//   OVERSAMPLE   : sample ticks per bit period
//   SAMPLE_LO/MID/HI : sample-counter values at which the 3-sample vote is taken
//   maj3()       : 2-of-3 majority helper
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_LO  = 7;
   localparam int SAMPLE_MID = 8;
   localparam int SAMPLE_HI  = 9;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing the 16x oversampling tick.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   tick_o  : one-cycle pulse every DIVISOR clocks (at terminal count)
// The counter is never realigned to the line; the receiver absorbs the
// resulting phase error of up to one tick.
module uart_baud_tick #(
   parameter int DIVISOR = 27
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == CNT_LAST);
   assign cnt_d   = at_last ? '0 : cnt_q + CNT_W'(1);
   assign tick_o  = at_last;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with 16x oversampling.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   rx        : asynchronous serial line, idles high
//   rx_data   : received byte (LSB first on the wire)
//   rx_valid  : rx_data holds an unconsumed byte
//   rx_ready  : consumer accepts the byte when rx_valid & rx_ready
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a byte completes while one is still held
//   busy      : high whenever the FSM is not in IDLE
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DIVISOR     = 27,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [3:0] SC_LO   = 4'(SAMPLE_LO);
   localparam logic [3:0] SC_MID  = 4'(SAMPLE_MID);
   localparam logic [3:0] SC_HI   = 4'(SAMPLE_HI);
   localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);

   logic                   tick;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   uart_state_e state_q, state_d;
   logic [3:0]  sc_q, sc_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [1:0]  samp_q, samp_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        armed_q, armed_d;
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;
   logic        vote;

   uart_baud_tick #(
      .DIVISOR(DIVISOR)
   ) u_baud_tick (
      .clk_i (clk),
      .rst_ni(rst_n),
      .tick_o(tick)
   );

   // Synchroniser resets to the idle level so reset itself never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // The third vote is the live sample at SAMPLE_HI, so the decision lands on that tick.
   assign vote = maj3(samp_q[0], samp_q[1], rx_s);

   always_comb begin
      state_d     = state_q;
      sc_d        = sc_q;
      bit_idx_d   = bit_idx_q;
      samp_d      = samp_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = valid_q;
      armed_d     = armed_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end

      // Arming is qualified by a tick, which is always later than the
      // synchroniser flushing its reset value; a line held low through
      // reset therefore cannot arm the receiver.
      if (tick && rx_s) begin
         armed_d = 1'b1;
      end

      if (tick) begin
         if (sc_q == SC_LO) begin
            samp_d[0] = rx_s;
         end
         if (sc_q == SC_MID) begin
            samp_d[1] = rx_s;
         end
      end

      unique case (state_q)
         IDLE: begin
            sc_d = '0;
            // Level-sensitive start: a start edge that arrives while STOP is
            // still finishing is picked up as soon as IDLE is reached.
            if (armed_q && !rx_s) begin
               state_d = START;
            end
         end

         START: begin
            if (tick) begin
               sc_d = sc_q + 4'd1;
               if (sc_q == SC_HI && vote) begin
                  state_d = IDLE;
               end else if (sc_q == SC_LAST) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end
            end
         end

         DATA: begin
            if (tick) begin
               sc_d = sc_q + 4'd1;
               if (sc_q == SC_HI) begin
                  shreg_d = {vote, shreg_q[7:1]};
               end
               if (sc_q == SC_LAST) begin
                  if (bit_idx_q == 3'd7) begin
                     state_d = STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end
         end

         STOP: begin
            if (tick) begin
               sc_d = sc_q + 4'd1;
               if (sc_q == SC_HI) begin
                  state_d = IDLE;
                  if (vote) begin
                     // A same-cycle handshake frees the holding register.
                     if (!valid_q || rx_ready) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end else begin
                     // Disarm so a break produces a single error until the line idles high.
                     frame_err_d = 1'b1;
                     armed_d     = 1'b0;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sc_q        <= '0;
         bit_idx_q   <= '0;
         samp_q      <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         armed_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sc_q        <= sc_d;
         bit_idx_q   <= bit_idx_d;
         samp_q      <= samp_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         armed_q     <= armed_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// tb_uart_receiver: directed bench for uart_receiver at DIVISOR=27 (432 clk/bit).
module tb_uart_receiver;

   localparam int BIT_P = 432;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Event counters maintained by the monitor; the stimulus only reads them.
   int          fe_cnt   = 0;
   int          ov_cnt   = 0;
   int          vld_cnt  = 0;
   logic [7:0]  last_data = 8'h00;
   logic        vld_prev = 1'b0;

   uart_receiver #(
      .DIVISOR    (27),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (rx_valid && !vld_prev) begin
            vld_cnt++;
            last_data = rx_data;
         end
      end
      vld_prev = rx_valid;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int bitp, input logic stop_lvl);
      rx = 1'b0;
      wait_clks(bitp);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(bitp);
      end
      rx = stop_lvl;
      wait_clks(bitp);
   endtask

   initial begin
      int fe0, ov0, vld0, busy_hits;
      int periods [2];
      logic [7:0] pats [3];
      periods[0] = 419;
      periods[1] = 445;
      pats[0] = 8'h00;
      pats[1] = 8'hFF;
      pats[2] = 8'h5A;

      rst_n    = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      wait_clks(5);
      check("reset_rx_data",   32'(rx_data),   32'h00);
      check("reset_rx_valid",  32'(rx_valid),  32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_overrun",   32'(overrun),   32'h0);
      check("reset_busy",      32'(busy),      32'h0);
      rst_n = 1'b1;
      wait_clks(2 * BIT_P);

      // Single byte
      fe0 = fe_cnt; ov0 = ov_cnt; vld0 = vld_cnt;
      send_byte(8'hA5, BIT_P, 1'b1);
      wait_clks(2 * BIT_P);
      check("single_vld_count", 32'(vld_cnt - vld0), 32'd1);
      check("single_data",      32'(last_data),      32'hA5);
      check("single_frame_err", 32'(fe_cnt - fe0),   32'd0);
      check("single_overrun",   32'(ov_cnt - ov0),   32'd0);

      // Glitch rejection
      fe0 = fe_cnt; vld0 = vld_cnt;
      rx = 1'b0;
      wait_clks(50);
      check("glitch_busy_rise", 32'(busy), 32'h1);
      wait_clks(50);
      rx = 1'b1;
      wait_clks(10 * BIT_P);
      check("glitch_busy_fall", 32'(busy),           32'h0);
      check("glitch_no_vld",    32'(vld_cnt - vld0), 32'd0);
      check("glitch_no_fe",     32'(fe_cnt - fe0),   32'd0);

      // Framing error followed by a 5-frame break
      fe0 = fe_cnt; vld0 = vld_cnt;
      send_byte(8'h3C, BIT_P, 1'b0);
      check("ferr_pulse_once", 32'(fe_cnt - fe0), 32'd1);
      fe0 = fe_cnt;
      busy_hits = 0;
      for (int i = 0; i < 5 * 10 * BIT_P; i++) begin
         @(negedge clk);
         if (busy) busy_hits++;
      end
      check("break_no_busy",  32'(busy_hits),      32'd0);
      check("break_no_fe",    32'(fe_cnt - fe0),   32'd0);
      check("break_no_vld",   32'(vld_cnt - vld0), 32'd0);
      rx = 1'b1;
      wait_clks(2 * BIT_P);
      vld0 = vld_cnt;
      send_byte(8'h55, BIT_P, 1'b1);
      wait_clks(2 * BIT_P);
      check("after_break_vld",  32'(vld_cnt - vld0), 32'd1);
      check("after_break_data", 32'(last_data),      32'h55);

      // Overrun
      rx_ready = 1'b0;
      fe0 = fe_cnt; ov0 = ov_cnt; vld0 = vld_cnt;
      send_byte(8'h11, BIT_P, 1'b1);
      send_byte(8'h22, BIT_P, 1'b1);
      wait_clks(2 * BIT_P);
      check("ovr_vld_count", 32'(vld_cnt - vld0), 32'd1);
      check("ovr_rx_valid",  32'(rx_valid),       32'h1);
      check("ovr_rx_data",   32'(rx_data),        32'h11);
      check("ovr_pulse",     32'(ov_cnt - ov0),   32'd1);
      check("ovr_no_fe",     32'(fe_cnt - fe0),   32'd0);
      rx_ready = 1'b1;
      wait_clks(1);
      check("ovr_drained", 32'(rx_valid), 32'h0);
      wait_clks(BIT_P);

      // Baud tolerance
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 3; k++) begin
            vld0 = vld_cnt;
            send_byte(pats[k], periods[p], 1'b1);
            wait_clks(periods[p]);
            check($sformatf("tol_%0d_vld", periods[p]),  32'(vld_cnt - vld0), 32'd1);
            check($sformatf("tol_%0d_data", periods[p]), 32'(last_data),      32'(pats[k]));
         end
      end
      wait_clks(BIT_P);

      // Reset during bit 4 of 0x0F, then 0x81
      rx = 1'b0;
      wait_clks(BIT_P);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         wait_clks(BIT_P);
      end
      rx = 1'b0;
      wait_clks(200);
      rst_n = 1'b0;
      wait_clks(20);
      check("midreset_rx_data",   32'(rx_data),   32'h00);
      check("midreset_rx_valid",  32'(rx_valid),  32'h0);
      check("midreset_frame_err", 32'(frame_err), 32'h0);
      check("midreset_overrun",   32'(overrun),   32'h0);
      check("midreset_busy",      32'(busy),      32'h0);
      rst_n = 1'b1;
      fe0 = fe_cnt; vld0 = vld_cnt;
      wait_clks(BIT_P - 220);
      wait_clks(3 * BIT_P);
      rx = 1'b1;
      wait_clks(3 * BIT_P);
      check("midreset_no_spurious", 32'(vld_cnt - vld0), 32'd0);
      send_byte(8'h81, BIT_P, 1'b1);
      wait_clks(2 * BIT_P);
      check("post_reset_vld",  32'(vld_cnt - vld0), 32'd1);
      check("post_reset_data", 32'(last_data),      32'h81);
      check("post_reset_no_fe", 32'(fe_cnt - fe0),  32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
